spi_txn_sched: RTL and testbench

Transaction scheduler that shares one byte-wide SPI master engine among `NUM_REQ` requesters. It grants the engine round-robin and sequences each multi-byte transaction through the engine's `start`/`done` byte handshake, with a programmable idle gap between bytes. It returns every received byte to the granted requester. It sits between the PIM-side requesters (command and data paths) and the SPI master.

---
 rtl/spi_sched_pkg.sv | 20 ++
 rtl/spi_rr_arbiter.sv | 40 ++++
 rtl/spi_txn_sched.sv | 180 ++++++++++++++++++
 tb/tb_spi_txn_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and constants for the SPI transaction scheduler.
//   sched_state_t      - scheduler FSM state encoding
//   SPI_BYTE_W         - width of one SPI engine byte
//   DEF_GAP_CYCLES     - default idle cycles between engine done and next start
//   DEF_TIMEOUT_CYCLES - default per-byte watchdog limit (timeout build only)
package spi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    BUSY   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } sched_state_t;

  localparam int SPI_BYTE_W         = 8;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin arbiter.
// The search starts at last_winner+1 (mod NUM_REQ), so the previous winner has
// the lowest priority.
// Ports:
//   req         in  NUM_REQ  request vector
//   last_winner in  IDX_W    index of the previously granted requester
//   winner      out NUM_REQ  one-hot winner (all zero when no request)
//   winner_idx  out IDX_W    index of the winner (0 when no request)
module spi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_winner) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        winner[cand_idx] = 1'b1;
        winner_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/spi_txn_sched.sv
// spi_txn_sched: shares one byte-wide SPI master engine among NUM_REQ
// requesters. Grants round-robin, runs each multi-byte transaction through the
// engine start/done handshake with GAP_CYCLES idle cycles between bytes, and
// returns every received byte to the granted requester.
//
// Handshake: gnt is held for the whole transaction; tx_pop pulses in the cycle
// the granted requester's tx_data is consumed (requester advances next cycle);
// rx_valid pulses for one cycle with rx_data; txn_done pulses for one cycle in
// the last gnt cycle, qualified by txn_err. spi_start pulses once per byte and
// only one byte is ever outstanding; spi_done is ignored outside BUSY.
//
// Optional build macro SPI_TXN_SCHED_TIMEOUT_EN: adds a per-byte watchdog that
// aborts the transaction with txn_err=1 after TIMEOUT_CYCLES without spi_done.
// Without it txn_err is tied low and BUSY waits indefinitely.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req, req_len, tx_data  requester side (req_len sampled at grant only)
//   gnt, tx_pop, rx_data, rx_valid, txn_done, txn_err  requester side outputs
//   spi_start, spi_tx, spi_done, spi_rx                engine side
//   state                  current FSM state (observability)
module spi_txn_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int LEN_W          = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*SPI_BYTE_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          tx_pop,
  output logic [SPI_BYTE_W-1:0]         rx_data,
  output logic                          rx_valid,
  output logic                          txn_done,
  output logic                          txn_err,
  output logic                          spi_start,
  output logic [SPI_BYTE_W-1:0]         spi_tx,
  input  logic                          spi_done,
  input  logic [SPI_BYTE_W-1:0]         spi_rx,
  output sched_state_t                  state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // Configurations outside the supported range build nothing extra here; the
  // block only documents the legal parameter space next to the logic.
  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_unsupported_cfg
  end

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_winner;
  logic [LEN_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap_cnt;

`ifdef SPI_TXN_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd;
`else
  assign txn_err = 1'b0;
`endif

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req),
    .last_winner (last_winner),
    .winner      (win_oh),
    .winner_idx  (win_idx)
  );

  // All outputs are registered. spi_start/tx_pop are raised on the transition
  // into START so they are high exactly while the FSM sits in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_idx     <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      gap_cnt     <= '0;
      tx_pop      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      txn_done    <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx      <= '0;
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
      txn_err     <= 1'b0;
      wd          <= '0;
`endif
    end else begin
      tx_pop    <= 1'b0;
      spi_start <= 1'b0;
      rx_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= win_oh;
            gnt_idx <= win_idx;
            cnt     <= req_len[win_idx*LEN_W +: LEN_W];
            if (req_len[win_idx*LEN_W +: LEN_W] == '0) begin
              state <= FINISH;
            end else begin
              spi_start <= 1'b1;
              tx_pop    <= 1'b1;
              spi_tx    <= tx_data[win_idx*SPI_BYTE_W +: SPI_BYTE_W];
              state     <= START;
            end
          end
        end
        START: begin
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
          wd <= '0;
`endif
          state <= BUSY;
        end
        BUSY: begin
          if (spi_done) begin
            rx_data  <= spi_rx;
            rx_valid <= 1'b1;
            cnt      <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              txn_done <= 1'b1;
              state    <= FINISH;
            end else begin
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
          // Fire one cycle early so txn_done lands TIMEOUT_CYCLES after spi_start.
          else if (wd == WD_W'(TIMEOUT_CYCLES - 2)) begin
            txn_done <= 1'b1;
            txn_err  <= 1'b1;
            state    <= FINISH;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == '0) begin
            spi_start <= 1'b1;
            tx_pop    <= 1'b1;
            spi_tx    <= tx_data[gnt_idx*SPI_BYTE_W +: SPI_BYTE_W];
            state     <= START;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        FINISH: begin
          // A zero-length grant enters with txn_done low and spends one extra
          // cycle here so txn_done still coincides with the last gnt cycle.
          if (txn_done) begin
            txn_done    <= 1'b0;
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
            txn_err     <= 1'b0;
`endif
            gnt         <= '0;
            last_winner <= gnt_idx;
            state       <= IDLE;
          end else begin
            txn_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sched.sv
// tb_spi_txn_sched: directed self-checking bench for spi_txn_sched.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_spi_txn_sched;
  import spi_sched_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [7:0]   req_len;
  logic [15:0]  tx_data;
  logic [1:0]   gnt;
  logic         tx_pop;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         txn_done;
  logic         txn_err;
  logic         spi_start;
  logic [7:0]   spi_tx;
  logic         spi_done;
  logic [7:0]   spi_rx;
  sched_state_t state;

  int n_vec  = 0;
  int n_miss = 0;

  spi_txn_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_len   (req_len),
    .tx_data   (tx_data),
    .gnt       (gnt),
    .tx_pop    (tx_pop),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .txn_done  (txn_done),
    .txn_err   (txn_err),
    .spi_start (spi_start),
    .spi_tx    (spi_tx),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx),
    .state     (state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #2 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       32'h0);
    chk({tag, "_tx_pop"},    32'(tx_pop),    32'h0);
    chk({tag, "_rx_data"},   32'(rx_data),   32'h0);
    chk({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
    chk({tag, "_txn_done"},  32'(txn_done),  32'h0);
    chk({tag, "_txn_err"},   32'(txn_err),   32'h0);
    chk({tag, "_spi_start"}, 32'(spi_start), 32'h0);
    chk({tag, "_spi_tx"},    32'(spi_tx),    32'h0);
    chk({tag, "_state"},     32'(state),     32'(IDLE));
  endtask

  // Entered at the falling edge where spi_start is expected. Plays a loopback
  // engine answering after lat BUSY cycles, then checks rx and either txn_done
  // (last byte) or the GAP spacing up to the next expected spi_start.
  task automatic do_byte(input int r, input logic [1:0] eg, input logic [7:0] exp_tx,
                         input logic [7:0] nxt, input bit last, input int lat);
    chk("start",  32'(spi_start), 32'h1);
    chk("tx_pop", 32'(tx_pop),    32'h1);
    chk("spi_tx", 32'(spi_tx),    32'(exp_tx));
    chk("gnt",    32'(gnt),       32'(eg));
    tx_data[r*8 +: 8] = nxt;
    step();
    chk("busy_no_start", 32'(spi_start), 32'h0);
    chk("busy_state",    32'(state),     32'(BUSY));
    for (int i = 1; i < lat; i++) step();
    spi_done = 1'b1;
    spi_rx   = exp_tx;
    step();
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    chk("rx_valid",  32'(rx_valid),  32'h1);
    chk("rx_data",   32'(rx_data),   32'(exp_tx));
    chk("gnt_held",  32'(gnt),       32'(eg));
    chk("txn_done",  32'(txn_done),  32'(last));
    chk("gap_start", 32'(spi_start), 32'h0);
    if (last) begin
      chk("txn_err", 32'(txn_err), 32'h0);
    end else begin
      for (int g = 1; g < DEF_GAP_CYCLES; g++) begin
        step();
        chk("gap_no_start", 32'(spi_start), 32'h0);
        chk("gap_rx_valid", 32'(rx_valid),  32'h0);
      end
      step();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 2'b00;
    req_len  = 8'h00;
    tx_data  = 16'h0000;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // Three-byte transaction from requester 0.
    req = 2'b01; req_len = 8'h03; tx_data = 16'h00A5;
    step();
    do_byte(0, 2'b01, 8'hA5, 8'h3C, 1'b0, 1);
    do_byte(0, 2'b01, 8'h3C, 8'hF0, 1'b0, 2);
    do_byte(0, 2'b01, 8'hF0, 8'h00, 1'b1, 1);
    req = 2'b00;
    step();
    chk("t1_gnt_clear",  32'(gnt),      32'h0);
    chk("t1_done_pulse", 32'(txn_done), 32'h0);

    // Both requesters hold req: grants alternate, requester 0 just won.
    req = 2'b11; req_len = 8'h11; tx_data = 16'h2211;
    for (int t = 0; t < 4; t++) begin
      step();
      if (t % 2 == 0) do_byte(1, 2'b10, 8'h22, 8'h22, 1'b1, 1);
      else            do_byte(0, 2'b01, 8'h11, 8'h11, 1'b1, 1);
      if (t == 3) req = 2'b00;
      step();
      chk("t2_gnt_idle", 32'(gnt),   32'h0);
      chk("t2_state",    32'(state), 32'(IDLE));
    end

    // Zero-length grant for requester 1.
    req = 2'b10; req_len = 8'h00;
    step();
    chk("t3_gnt",       32'(gnt),       32'h2);
    chk("t3_no_start",  32'(spi_start), 32'h0);
    chk("t3_no_pop",    32'(tx_pop),    32'h0);
    chk("t3_not_done",  32'(txn_done),  32'h0);
    step();
    chk("t3_done",      32'(txn_done),  32'h1);
    chk("t3_err",       32'(txn_err),   32'h0);
    chk("t3_no_start2", 32'(spi_start), 32'h0);
    chk("t3_no_rx",     32'(rx_valid),  32'h0);
    req = 2'b00;
    step();
    chk("t3_gnt_clear", 32'(gnt),       32'h0);

    // Requester 0 drops req after byte 1 of 4; requester 1 follows.
    req = 2'b11; req_len = 8'h14; tx_data = 16'h7701;
    step();
    do_byte(0, 2'b01, 8'h01, 8'h02, 1'b0, 1);
    req = 2'b10;
    do_byte(0, 2'b01, 8'h02, 8'h03, 1'b0, 1);
    do_byte(0, 2'b01, 8'h03, 8'h04, 1'b0, 3);
    do_byte(0, 2'b01, 8'h04, 8'h00, 1'b1, 1);
    step();
    chk("t4_gnt_idle", 32'(gnt), 32'h0);
    step();
    do_byte(1, 2'b10, 8'h77, 8'h77, 1'b1, 1);
    req = 2'b00;
    step();
    chk("t4_gnt_clear", 32'(gnt), 32'h0);

    // Engine never answers.
    req = 2'b01; req_len = 8'h01; tx_data = 16'h00C3;
    step();
    chk("t5_start", 32'(spi_start), 32'h1);
    req = 2'b00;
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
    begin
      int k;
      k = 0;
      do begin
        step();
        k++;
      end while (!txn_done && k < DEF_TIMEOUT_CYCLES + 100);
      chk("t5_timeout_cycles", 32'(k),        32'(DEF_TIMEOUT_CYCLES));
      chk("t5_txn_err",        32'(txn_err),  32'h1);
      chk("t5_no_rx",          32'(rx_valid), 32'h0);
      chk("t5_gnt",            32'(gnt),      32'h1);
      step();
      chk("t5_gnt_clear",      32'(gnt),      32'h0);
    end
`else
    begin
      bit seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 64; i++) begin
        step();
        if (txn_done) seen_done = 1'b1;
      end
      chk("t5_no_done",    32'(seen_done), 32'h0);
      chk("t5_stuck_busy", 32'(state),     32'(BUSY));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("t5_recover", 32'(state), 32'(IDLE));
    end
`endif

    // Requester 0 completes once, then reset hits the GAP of its next transfer.
    req = 2'b01; req_len = 8'h01; tx_data = 16'h005A;
    step();
    do_byte(0, 2'b01, 8'h5A, 8'h5A, 1'b1, 1);
    req = 2'b00;
    step();
    req = 2'b01; req_len = 8'h02; tx_data = 16'h0011;
    step();
    chk("t6_start", 32'(spi_start), 32'h1);
    step();
    spi_done = 1'b1;
    spi_rx   = 8'h11;
    step();
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    chk("t6_rx_valid", 32'(rx_valid), 32'h1);
    step();
    chk("t6_in_gap", 32'(state), 32'(GAP));
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    req = 2'b11; req_len = 8'h11; tx_data = 16'h2233;
    step();
    rst_n = 1'b1;
    step();
    do_byte(0, 2'b01, 8'h33, 8'h33, 1'b1, 1);
    req = 2'b00;
    step();
    chk("t6_gnt_clear", 32'(gnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
